// File: rtl/enc_velocity_est.sv
// Per-window signed velocity estimate from a wrapping encoder position count,
// with a 2^AVG_LOG2-window moving average of the per-window delta.
module enc_velocity_est #(
  parameter int COUNTS_PER_REV = 2047,
  parameter int COUNT_SIZE     = 11,
  parameter int WINDOW_CYCLES  = 100000,
  parameter int AVG_LOG2       = 3
) (
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [COUNT_SIZE-1:0] pos,
  input  logic                  home,
  output logic [COUNT_SIZE:0]   vel_delta,
  output logic                  vel_valid,
  output logic                  vel_home,
  output logic [COUNT_SIZE:0]   vel_avg,
  output logic                  avg_valid,
  output logic                  avg_full,
  output logic [1:0]            fsm_state
);

  localparam int DW    = COUNT_SIZE + 1;
  localparam int SW    = DW + AVG_LOG2;
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int M     = COUNTS_PER_REV + 1;
  localparam int CW    = $clog2(WINDOW_CYCLES);
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  state_t                state, state_next;
  logic                  tick;
  logic                  run_ok;
  logic [CW-1:0]         win_cnt;
  logic [COUNT_SIZE-1:0] cur_q, prev_q;
  logic                  home_seen;
  logic                  s1_valid, s1_bad;
  logic signed [DW-1:0]  hist [DEPTH];
  logic [AVG_LOG2-1:0]   wr_ptr;
  logic signed [SW-1:0]  sum, sum_next;
  logic signed [DW-1:0]  delta_w;

  // Shortest-path difference of two positions on a ring of M counts.
  function automatic logic signed [DW-1:0] wrap_delta(input logic [COUNT_SIZE-1:0] c,
                                                      input logic [COUNT_SIZE-1:0] p);
    int r;
    r = int'(c) - int'(p);
    if (r > M / 2 - 1) r = r - M;
    else if (r < -(M / 2)) r = r + M;
    return DW'(r);
  endfunction

  assign fsm_state = state;
  assign run_ok    = enable && (state != IDLE);
  assign delta_w   = wrap_delta(cur_q, prev_q);
  assign sum_next  = sum - SW'(hist[wr_ptr]) + SW'($signed(vel_delta));

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Dropping enable wins over a coincident tick: no sample is taken.
  always_comb begin
    state_next = state;
    tick       = 1'b0;
    case (state)
      IDLE:  if (enable) state_next = PRIME;
      PRIME: begin
        if (!enable) state_next = IDLE;
        else if (win_cnt == WIN_LAST) begin
          tick       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (!enable) state_next = IDLE;
        else if (win_cnt == WIN_LAST) tick = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) win_cnt <= '0;
    else if (!run_ok || tick) win_cnt <= '0;
    else win_cnt <= win_cnt + CW'(1);
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      cur_q     <= '0;
      prev_q    <= '0;
      home_seen <= 1'b0;
      s1_valid  <= 1'b0;
      s1_bad    <= 1'b0;
      vel_delta <= '0;
      vel_valid <= 1'b0;
      vel_home  <= 1'b0;
      vel_avg   <= '0;
      avg_valid <= 1'b0;
      avg_full  <= 1'b0;
      wr_ptr    <= '0;
      sum       <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      s1_valid  <= 1'b0;
      vel_valid <= 1'b0;
      avg_valid <= 1'b0;

      // A home anywhere in the window, or on the tick itself, poisons the sample.
      if (tick) begin
        cur_q     <= pos;
        prev_q    <= cur_q;
        s1_valid  <= (state == RUN);
        s1_bad    <= home_seen | home;
        home_seen <= home;
      end else if (home) begin
        home_seen <= 1'b1;
      end

      if (run_ok && s1_valid) begin
        vel_delta <= s1_bad ? '0 : delta_w;
        vel_home  <= s1_bad;
        vel_valid <= 1'b1;
      end

      if (run_ok && vel_valid) begin
        hist[wr_ptr] <= $signed(vel_delta);
        sum          <= sum_next;
        vel_avg      <= DW'(sum_next >>> AVG_LOG2);
        avg_valid    <= 1'b1;
        wr_ptr       <= wr_ptr + AVG_LOG2'(1);
        if (wr_ptr == '1) avg_full <= 1'b1;
      end

      if (state != IDLE && !enable) avg_full <= 1'b0;

      if (state == IDLE && enable) begin
        sum      <= '0;
        wr_ptr   <= '0;
        avg_full <= 1'b0;
        for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_enc_velocity_est.sv
// Bench for enc_velocity_est: window driver pushes hand-computed results into
// expected queues; a negedge monitor pops and compares on every valid pulse.
module tb_enc_velocity_est;

  logic        sclk;
  logic        rstn;
  logic        enable;
  logic [10:0] pos;
  logic        home;
  logic [11:0] vel_delta;
  logic        vel_valid;
  logic        vel_home;
  logic [11:0] vel_avg;
  logic        avg_valid;
  logic        avg_full;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [12:0] exp_vel_q[$];
  logic [12:0] exp_avg_q[$];
  int          vel_t_q[$];
  int          avg_t_q[$];

  enc_velocity_est #(
    .COUNTS_PER_REV(2047),
    .COUNT_SIZE    (11),
    .WINDOW_CYCLES (16),
    .AVG_LOG2      (2)
  ) dut (
    .sclk     (sclk),
    .rstn     (rstn),
    .enable   (enable),
    .pos      (pos),
    .home     (home),
    .vel_delta(vel_delta),
    .vel_valid(vel_valid),
    .vel_home (vel_home),
    .vel_avg  (vel_avg),
    .avg_valid(avg_valid),
    .avg_full (avg_full),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor / scoreboard
  always @(negedge sclk) begin
    logic [12:0] e;
    int t;
    if (vel_valid) begin
      if (exp_vel_q.size() == 0) begin
        check("vel_valid_unexpected", 32'(vel_valid), 32'd0);
      end else begin
        e = exp_vel_q.pop_front();
        t = vel_t_q.pop_front();
        check("vel_home_delta", 32'({vel_home, vel_delta}), 32'(e));
        check("vel_latency", cyc, t);
      end
    end
    if (avg_valid) begin
      if (exp_avg_q.size() == 0) begin
        check("avg_valid_unexpected", 32'(avg_valid), 32'd0);
      end else begin
        e = exp_avg_q.pop_front();
        t = avg_t_q.pop_front();
        check("avg_full_value", 32'({avg_full, vel_avg}), 32'(e));
        check("avg_latency", cyc, t);
      end
    end
  end

  // driver tasks
  task automatic start();
    @(negedge sclk);
    enable = 1'b1;
  endtask

  // One 16-cycle window; iteration 15 is the tick cycle.
  task automatic run_window(input int p, input bit hm, input bit ht, input bit emit,
                            input int d, input bit vh, input int a, input bit f);
    for (int i = 0; i < 16; i++) begin
      @(negedge sclk);
      if (i == 0) pos = 11'(p);
      home = (hm && i == 5) || (ht && i == 15);
      if (i == 15 && emit) begin
        exp_vel_q.push_back({vh, 12'(d)});
        vel_t_q.push_back(cyc + 2);
        exp_avg_q.push_back({f, 12'(a)});
        avg_t_q.push_back(cyc + 3);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vel_delta"}, 32'(vel_delta), 32'd0);
    check({tag, "_vel_valid"}, 32'(vel_valid), 32'd0);
    check({tag, "_vel_home"},  32'(vel_home),  32'd0);
    check({tag, "_vel_avg"},   32'(vel_avg),   32'd0);
    check({tag, "_avg_valid"}, 32'(avg_valid), 32'd0);
    check({tag, "_avg_full"},  32'(avg_full),  32'd0);
    check({tag, "_state"},     32'(fsm_state), 32'd0);
  endtask

  initial begin
    rstn   = 1'b0;
    enable = 1'b0;
    pos    = '0;
    home   = 1'b0;
    repeat (3) @(negedge sclk);
    check_all_zero("reset");
    rstn = 1'b1;

    // constant rate, then forward and reverse wrap
    start();
    run_window(100,  0, 0, 0,    0, 0,   0, 0);
    run_window(105,  0, 0, 1,    5, 0,   1, 0);
    run_window(110,  0, 0, 1,    5, 0,   2, 0);
    run_window(115,  0, 0, 1,    5, 0,   3, 0);
    run_window(120,  0, 0, 1,    5, 0,   5, 1);
    run_window(125,  0, 0, 1,    5, 0,   5, 1);
    run_window(2040, 0, 0, 1, -133, 0, -30, 1);
    run_window(5,    0, 0, 1,   13, 0, -28, 1);
    run_window(3,    0, 0, 1,   -2, 0, -30, 1);
    run_window(2045, 0, 0, 1,   -6, 0, -32, 1);

    // disable mid-window: outputs hold, avg_full drops, no pulses
    repeat (6) @(negedge sclk);
    enable = 1'b0;
    repeat (10) @(negedge sclk);
    check("idle_vel_delta", 32'($signed(vel_delta)), -6);
    check("idle_vel_avg",   32'($signed(vel_avg)),  -32);
    check("idle_avg_full",  32'(avg_full),  32'd0);
    check("idle_state",     32'(fsm_state), 32'd0);

    // re-enable: prime window silent, averaging from a cleared buffer
    start();
    run_window(1000, 0, 0, 0,  0, 0,  0, 0);
    run_window(1004, 0, 0, 1,  4, 0,  1, 0);
    run_window(1008, 0, 0, 1,  4, 0,  2, 0);
    run_window(1006, 0, 0, 1, -2, 0,  1, 0);
    run_window(1003, 0, 0, 1, -3, 0,  0, 1);
    run_window(1000, 0, 0, 1, -3, 0, -1, 1);

    // home mid-window, then home on the tick cycle
    run_window(1010, 1, 0, 1, 0, 1, -2, 1);
    run_window(1015, 0, 0, 1, 5, 0, -1, 1);
    run_window(1020, 0, 1, 1, 0, 1,  0, 1);
    run_window(1025, 0, 0, 1, 0, 1,  1, 1);
    run_window(1030, 0, 0, 1, 5, 0,  2, 1);

    // reset between E0 and E1 of a sampled window
    run_window(1035, 0, 0, 0, 0, 0, 0, 0);
    @(negedge sclk);
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge sclk);
    rstn = 1'b1;
    repeat (20) @(negedge sclk);
    enable = 1'b0;
    repeat (4) @(negedge sclk);

    while (exp_vel_q.size() > 0) begin
      check("vel_missing", 32'(exp_vel_q.size()), 32'd0);
      void'(exp_vel_q.pop_front());
    end
    while (exp_avg_q.size() > 0) begin
      check("avg_missing", 32'(exp_avg_q.size()), 32'd0);
      void'(exp_avg_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
